// File: rtl/veririsc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// veririsc_pkg : shared opcode/phase encodings for the VeriRisc sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package veririsc_pkg;

  localparam int OPC_W = 3;
  localparam int PH_W  = 3;

  localparam logic [OPC_W-1:0] OP_HLT = 3'd0;
  localparam logic [OPC_W-1:0] OP_SKZ = 3'd1;
  localparam logic [OPC_W-1:0] OP_ADD = 3'd2;
  localparam logic [OPC_W-1:0] OP_AND = 3'd3;
  localparam logic [OPC_W-1:0] OP_XOR = 3'd4;
  localparam logic [OPC_W-1:0] OP_LDA = 3'd5;
  localparam logic [OPC_W-1:0] OP_STO = 3'd6;
  localparam logic [OPC_W-1:0] OP_JMP = 3'd7;

  localparam logic [PH_W-1:0] PH_INST_ADDR  = 3'd0;
  localparam logic [PH_W-1:0] PH_INST_FETCH = 3'd1;
  localparam logic [PH_W-1:0] PH_INST_LOAD  = 3'd2;
  localparam logic [PH_W-1:0] PH_IDLE       = 3'd3;
  localparam logic [PH_W-1:0] PH_OP_ADDR    = 3'd4;
  localparam logic [PH_W-1:0] PH_OP_FETCH   = 3'd5;
  localparam logic [PH_W-1:0] PH_ALU_OP     = 3'd6;
  localparam logic [PH_W-1:0] PH_STORE      = 3'd7;

  // Instructions that read an operand from memory into the accumulator.
  function automatic logic is_aluop(input logic [OPC_W-1:0] opc);
    return (opc == OP_ADD) || (opc == OP_AND) || (opc == OP_XOR) || (opc == OP_LDA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/risc_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// risc_controller : eight-phase fetch/decode/execute sequencer with halt/resume
// Rev 1.0
// ----------------------------------------------------------------------------
module risc_controller
  import veririsc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opcode,
  input  logic             zero,
  input  logic             resume,
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic             halt,
  output logic             halted,
  output logic [PH_W-1:0]  phase
);

  logic [PH_W-1:0] r_phase;
  logic            r_halted;
  logic [PH_W-1:0] w_phase_nxt;
  logic            w_halted_nxt;
  logic            w_alu;
  logic            w_is_hlt;

  assign w_alu    = is_aluop(opcode);
  assign w_is_hlt = (opcode == OP_HLT);
  assign phase    = r_phase;
  assign halted   = r_halted;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase  <= PH_INST_ADDR;
      r_halted <= 1'b0;
    end else begin
      r_phase  <= w_phase_nxt;
      r_halted <= w_halted_nxt;
    end
  end

  always_comb begin
    w_phase_nxt  = r_phase;
    w_halted_nxt = r_halted;
    sel          = 1'b0;
    rd           = 1'b0;
    ld_ir        = 1'b0;
    inc_pc       = 1'b0;
    ld_pc        = 1'b0;
    ld_ac        = 1'b0;
    wr           = 1'b0;
    data_e       = 1'b0;
    halt         = 1'b0;

    if (r_halted) begin
      // Frozen: only the halt indication is active until a resume arrives.
      halt = 1'b1;
      if (resume) begin
        w_phase_nxt  = PH_INST_ADDR;
        w_halted_nxt = 1'b0;
      end
    end else begin
      w_phase_nxt = r_phase + PH_W'(1);
      case (r_phase)
        PH_INST_ADDR: begin
          sel = 1'b1;
        end
        PH_INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        PH_INST_LOAD, PH_IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        PH_OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = w_is_hlt;
          // Landing in phase 5 is the normal increment; the phase then freezes.
          if (w_is_hlt) w_halted_nxt = 1'b1;
        end
        PH_OP_FETCH: begin
          rd = w_alu;
        end
        PH_ALU_OP: begin
          rd     = w_alu;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        PH_STORE: begin
          rd     = w_alu;
          ld_ac  = w_alu;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
          wr     = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_risc_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_risc_controller : directed scoreboard bench for risc_controller
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_risc_controller;
  import veririsc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] opcode = 3'd0;
  logic       zero = 1'b0;
  logic       resume = 1'b0;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, halted;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;
  logic [12:0] exp_q[$];
  logic [2:0]  m_phase  = 3'd0;
  logic        m_halted = 1'b0;

  always #5 clk = ~clk;

  risc_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .resume(resume),
    .sel(sel), .rd(rd), .ld_ir(ld_ir), .inc_pc(inc_pc), .ld_pc(ld_pc),
    .ld_ac(ld_ac), .wr(wr), .data_e(data_e), .halt(halt), .halted(halted),
    .phase(phase)
  );

  // Expected {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt,halted,phase}
  function automatic logic [12:0] model(input logic [2:0] ph, input logic hd,
                                        input logic [2:0] opc, input logic z);
    logic alu;
    logic [12:0] v;
    alu = (opc == 3'd2) || (opc == 3'd3) || (opc == 3'd4) || (opc == 3'd5);
    if (hd) return {9'b0_0000_0001, 1'b1, ph};
    v[12]  = (ph <= 3'd3);
    v[11]  = (ph >= 3'd1 && ph <= 3'd3) || (ph >= 3'd5 && alu);
    v[10]  = (ph == 3'd2) || (ph == 3'd3);
    v[9]   = (ph == 3'd4) || (ph == 3'd6 && opc == 3'd1 && z);
    v[8]   = (ph >= 3'd6) && (opc == 3'd7);
    v[7]   = (ph == 3'd7) && alu;
    v[6]   = (ph == 3'd7) && (opc == 3'd6);
    v[5]   = (ph >= 3'd6) && (opc == 3'd6);
    v[4]   = (ph == 3'd4) && (opc == 3'd0);
    v[3]   = 1'b0;
    v[2:0] = ph;
    return v;
  endfunction

  task automatic compare(input string tag);
    logic [12:0] got, exp;
    got = {sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt, halted, phase};
    exp = exp_q.pop_front();
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s ph%0d got=%013b exp=%013b", tag, m_phase, got, exp);
    end
    n_tests++;
    assert (!(ld_pc === 1'b1 && inc_pc === 1'b1)) else begin
      n_fail++;
      $error("FAIL %s pc_excl got=%b%b exp=not 11", tag, ld_pc, inc_pc);
    end
  endtask

  // Called in the low half of the clock: drive, sample, then advance one edge.
  task automatic step(input string tag, input logic [2:0] opc, input logic z,
                      input logic res);
    opcode = opc; zero = z; resume = res;
    exp_q.push_back(model(m_phase, m_halted, opc, z));
    #1;
    compare(tag);
    @(posedge clk);
    if (m_halted) begin
      if (res) begin m_phase = 3'd0; m_halted = 1'b0; end
    end else begin
      if (m_phase == 3'd4 && opc == 3'd0) m_halted = 1'b1;
      m_phase = m_phase + 3'd1;
    end
    @(negedge clk);
  endtask

  task automatic instr(input string tag, input logic [2:0] opc, input logic z);
    for (int i = 0; i < 8; i++) step(tag, opc, z, 1'b0);
  endtask

  task automatic async_reset(input string tag);
    rst = 1'b1;
    m_phase = 3'd0; m_halted = 1'b0;
    #1;
    exp_q.push_back(13'b1_0000_0000_0000);
    compare(tag);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    exp_q.push_back(13'b1_0000_0000_0000);
    compare("reset_hold");
    @(negedge clk);
    rst = 1'b0;

    instr("lda", OP_LDA, 1'b0);
    instr("sto", OP_STO, 1'b0);
    instr("skz_z1", OP_SKZ, 1'b1);
    instr("skz_z0", OP_SKZ, 1'b0);
    instr("jmp", OP_JMP, 1'b1);
    instr("add", OP_ADD, 1'b1);
    instr("and", OP_AND, 1'b0);
    instr("xor", OP_XOR, 1'b1);

    // Halt entry, then ten frozen cycles with changing inputs.
    for (int i = 0; i < 5; i++) step("hlt", OP_HLT, 1'b0, 1'b0);
    n_tests++;
    assert (phase === 3'd5 && halted === 1'b1 && halt === 1'b1) else begin
      n_fail++;
      $error("FAIL hlt_entry got=%0d/%b/%b exp=5/1/1", phase, halted, halt);
    end
    for (int i = 0; i < 10; i++)
      step("halted", 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);

    step("resume", OP_JMP, 1'b1, 1'b1);
    n_tests++;
    assert (phase === 3'd0 && halted === 1'b0 && sel === 1'b1) else begin
      n_fail++;
      $error("FAIL resume_rel got=%0d/%b/%b exp=0/0/1", phase, halted, sel);
    end
    instr("post_resume", OP_LDA, 1'b0);

    // Resume held high: releases once, ignored while running, reapplies after next halt.
    for (int i = 0; i < 6; i++) step("hlt2", OP_HLT, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step("held_res", OP_STO, 1'b0, 1'b1);
    step("held_res_off", OP_ADD, 1'b0, 1'b0);

    // Reset mid-instruction at phase 5.
    for (int i = 0; i < 4; i++) step("pre_rst", OP_LDA, 1'b0, 1'b0);
    n_tests++;
    assert (phase === 3'd5) else begin
      n_fail++;
      $error("FAIL pre_rst_phase got=%0d exp=5", phase);
    end
    async_reset("rst_mid");
    instr("after_rst", OP_SKZ, 1'b1);

    // Reset mid-halt.
    for (int i = 0; i < 7; i++) step("hlt3", OP_HLT, 1'b1, 1'b0);
    async_reset("rst_halt");
    instr("after_rst2", OP_JMP, 1'b0);

    n_tests++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_empty got=%0d exp=0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/risc_controller.md
Name: risc_controller

Overview:
- Eight-phase instruction sequencer for the VeriRisc CPU.
- Steps a 3-bit phase through fetch, decode and execute.
- Drives the datapath strobes: program-counter `ld_pc`/`inc_pc`, instruction register, accumulator, memory read/write, bus driver, address mux.
- Decodes the 3-bit opcode from the instruction register and the accumulator zero flag, so the PC counter is loaded or incremented at the correct phase.

Parameters:
- None. Opcode and phase encodings are fixed 3-bit constants in the shared package.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous active-high reset
- opcode  input  3  opcode field of instruction register
- zero  input  1  accumulator-is-zero flag
- resume  input  1  restart request; honoured only while halted
- sel  output  1  address mux: 1 = PC address, 0 = operand address
- rd  output  1  memory read enable
- ld_ir  output  1  instruction register load
- inc_pc  output  1  PC counter enable (increment)
- ld_pc  output  1  PC counter load (jump)
- ld_ac  output  1  accumulator load
- wr  output  1  memory write strobe
- data_e  output  1  accumulator drives data bus
- halt  output  1  halt indication
- halted  output  1  sticky halted status
- phase  output  3  current phase, for debug/trace

Behaviour:
- Single register set: `phase[2:0]` and `halted`. All strobes are combinational from `phase`, `halted`, `opcode` and `zero`. No registered outputs besides `phase` and `halted`.
- Reset (async, active-high): `phase` = 0 (INST_ADDR), `halted` = 0. Outputs during reset: `sel` = 1, all other strobes 0, `halt` = 0.
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD | AND | XOR | LDA.
- Phase advance: `phase` increments by 1 every clock, wrapping 7 -> 0, while `halted` = 0. One instruction takes exactly 8 clocks.
- Strobes by phase (unlisted strobes are 0):
  - 0 INST_ADDR: `sel`.
  - 1 INST_FETCH: `sel`, `rd`.
  - 2 INST_LOAD: `sel`, `rd`, `ld_ir`.
  - 3 IDLE: `sel`, `rd`, `ld_ir`.
  - 4 OP_ADDR: `inc_pc`; `halt` = (opcode==HLT).
  - 5 OP_FETCH: `rd` = ALUOP.
  - 6 ALU_OP: `rd` = ALUOP; `inc_pc` = (opcode==SKZ & zero); `ld_pc` = (opcode==JMP); `data_e` = (opcode==STO).
  - 7 STORE: `rd` = ALUOP; `ld_ac` = ALUOP; `ld_pc` = (opcode==JMP); `data_e` = (opcode==STO); `wr` = (opcode==STO).
- Halt entry: on the clock edge ending phase 4 with opcode==HLT:
  - `halted` <= 1 and `phase` <= 5; `phase` then freezes.
  - The HLT instruction's own PC increment in phase 4 still happens.
- While halted: all strobes 0 except `halt` = 1 and `halted` = 1. `sel` = 0. Opcode and zero changes are ignored.
- Resume: `resume` = 1 at a rising edge while halted gives `halted` <= 0 and `phase` <= 0. The next instruction is fetched from the current PC.
- `resume` while not halted has no effect.
- `resume` held high continuously releases once, then has no effect until the next halt.
- `ld_pc` and `inc_pc` are never both 1 in the same cycle, guaranteed by the decode above.
- `opcode` is sampled combinationally. It must be stable from phase 3 onward; the IR is loaded in phases 2–3.
- Reset mid-instruction or mid-halt: immediate return to phase 0, `halted` = 0. No strobe glitches beyond the combinational decode of phase 0.

Decomposition:
- Shared package `veririsc_pkg`:
  - opcode localparams `OP_HLT`..`OP_JMP`
  - phase localparams `PH_INST_ADDR`..`PH_STORE`
  - widths `OPC_W` = 3, `PH_W` = 3
- No sub-module. The phase register plus halt flag is small enough inline. Strobe decode is a single combinational case on `phase`.

Test Plan:
- Reset: assert `rst` mid-cycle at phase 5 -> `phase` = 0, `sel` = 1, all other strobes 0, immediately (before next edge).
- LDA (opcode 5), zero = 0, 8 clocks:
  - phases 0..7 in order.
  - `rd` = 1 in phases 1, 2, 3, 5, 6, 7.
  - `ld_ir` = 1 in phases 2, 3.
  - `inc_pc` = 1 in phase 4 only.
  - `ld_ac` = 1 in phase 7 only.
  - `wr` never.
- STO (6): `data_e` = 1 in phases 6 and 7; `wr` = 1 in phase 7 only; `rd` = 0 in phases 5–7; `ld_ac` = 0.
- SKZ (1):
  - zero = 1: `inc_pc` = 1 in phases 4 and 6.
  - zero = 0: `inc_pc` = 1 in phase 4 only.
- JMP (7): `ld_pc` = 1 in phases 6 and 7; `inc_pc` = 1 only in phase 4; never `ld_pc` & `inc_pc` together.
- HLT (0), then resume:
  - phase 4: `halt` = 1, `inc_pc` = 1.
  - after edge: `halted` = 1, `phase` = 5, `halt` = 1.
  - 10 further clocks: `phase` stays 5, all strobes 0.
  - pulse `resume` for 1 clock -> `phase` = 0, `halted` = 0, `sel` = 1; next 8 clocks sequence normally.
